// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply is a shift-add into a 2*WIDTH product; divide is restoring, one
// quotient bit per clock. Both share one 2*WIDTH working register.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, divide by
// zero, signed overflow and zero-operand cases skip CALC and finish in two
// clocks.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands captured on the start edge
// CALC   | one shift-add / restoring-divide iteration per clock
// FINISH | sign correction, special-case forcing, result register load
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, next_state;

  logic               load;
  logic               step;

  logic [2:0]         op;
  logic               is_div;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   a_raw;
  logic               div0;
  logic               ovf;
  logic [CW-1:0]      cnt;

  logic               is_div_in;
  logic               a_signed_in;
  logic               b_signed_in;
  logic               a_neg_in;
  logic               b_neg_in;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic               div0_in;
  logic               ovf_in;
`ifdef MULDIV_EARLY_OUT_EN
  logic               early_in;
`endif

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_next;

  logic [2*WIDTH-1:0] mul_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   fin_val;

  // Decode the live inputs so the start edge can capture magnitudes and signs.
  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                  (funct3 == 3'b110);
    a_neg_in    = a_signed_in && a_bus[WIDTH-1];
    b_neg_in    = b_signed_in && b_bus[WIDTH-1];
    a_mag_in    = a_neg_in ? (~a_bus + 1'b1) : a_bus;
    b_mag_in    = b_neg_in ? (~b_bus + 1'b1) : b_bus;
    div0_in     = is_div_in && (b_bus == '0);
    // Only DIV (100) and REM (110) are signed divides, both have funct3[0]=0.
    ovf_in      = is_div_in && !funct3[0] && (a_bus == MOST_NEG) && (b_bus == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_in    = div0_in || ovf_in || (a_bus == '0) ||
                  (!is_div_in && (b_bus == '0));
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, capture/iterate strobes and busy.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          next_state = early_in ? FINISH : CALC;
`else
          next_state = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST_ITER) begin
          next_state = FINISH;
        end
      end
      FINISH: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One iteration of either algorithm; upper half is remainder / partial
  // product, lower half is quotient-in-progress / remaining multiplier bits.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        prod_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      end else begin
        prod_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      end
    end else begin
      prod_next = {mul_sum, prod[WIDTH-1:1]};
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op     <= '0;
      is_div <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_raw  <= '0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      op     <= funct3;
      is_div <= is_div_in;
      mcand  <= b_mag_in;
      // A zero multiplier leaves the product zero from the start, which keeps
      // a skipped multiply consistent with the iterated one.
      prod   <= {{WIDTH{1'b0}}, (!is_div_in && (b_bus == '0)) ? '0 : a_mag_in};
      neg_q  <= a_neg_in ^ b_neg_in;
      neg_r  <= a_neg_in;
      a_raw  <= a_bus;
      div0   <= div0_in;
      ovf    <= ovf_in;
      cnt    <= '0;
    end else if (step) begin
      prod <= prod_next;
      cnt  <= cnt + CW'(1);
    end
  end

  // Sign correction, half selection and special-case forcing for FINISH.
  always_comb begin
    mul_signed = neg_q ? (~prod + 1'b1) : prod;
    quo_signed = neg_q ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
    rem_signed = neg_r ? (~prod[2*WIDTH-1:WIDTH] + 1'b1) : prod[2*WIDTH-1:WIDTH];
    fin_val    = '0;
    case (op)
      3'b000:                 fin_val = mul_signed[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_val = mul_signed[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: begin
        if (div0)     fin_val = '1;
        else if (ovf) fin_val = MOST_NEG;
        else          fin_val = quo_signed;
      end
      default: begin
        if (div0)     fin_val = a_raw;
        else if (ovf) fin_val = '0;
        else          fin_val = rem_signed;
      end
    endcase
  end

  // Result register and one-cycle done pulse, both loaded on the FINISH edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        result <= fin_val;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a_bus = '0;
  logic [31:0] b_bus = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Negedge index (1 = cycle after the capture edge) at which done is expected.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit early;
    if (f[2]) early = (b == 0) || (a == 0) ||
                      (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    else      early = (a == 0) || (b == 0);
    return early ? 2 : 34;
`else
    return 34;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int n, busy_cnt, lat;
    bit seen;
    logic [31:0] want;
    want = model(f, a, b);
    lat  = exp_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; a_bus = a; b_bus = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); a_bus = $urandom; b_bus = $urandom;
    n = 1; busy_cnt = 0; seen = 0;
    while (n <= 60 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got no done want done by cycle %0d", tag, lat);
      return;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", tag, n, lat);
    end
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL %s result got %h want %h", tag, result, want);
    end
    checks++;
    if (busy_cnt !== n - 1) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cnt, n - 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done got %b want 0", tag, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got %b want 0", tag, done);
    end
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL %s result_hold got %h want %h", tag, result, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'h0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'h0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
  endtask

  task automatic test_directed();
    run_op(3'b000, 32'd7,        32'hFFFFFFFD, "mul_7_m3");
    run_op(3'b001, 32'h80000000, 32'h80000000, "mulh_min_min");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    run_op(3'b100, 32'hFFFFFFF9, 32'd2,        "div_m7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2,        "rem_m7_2");
    run_op(3'b101, 32'd100,      32'd7,        "divu_100_7");
    run_op(3'b111, 32'd100,      32'd7,        "remu_100_7");
    run_op(3'b101, 32'd5,        32'd0,        "divu_by0");
    run_op(3'b111, 32'd5,        32'd0,        "remu_by0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    run_op(3'b000, 32'd0,        32'h12345678, "mul_zero_a");
    run_op(3'b100, 32'd0,        32'd9,        "div_zero_dividend");
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), "random_op");
    end
  endtask

  task automatic test_back_to_back();
    int n, dones;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a_bus = 32'd100; b_bus = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1; dones = 0;
    while (n <= 60 && dones == 0) begin
      if (done === 1'b1) dones++;
      else begin
        start = (n == 10);
        if (n == 10) begin funct3 = 3'b000; a_bus = 32'h55; b_bus = 32'h66; end
        if (n == 15) a_bus = 32'hDEADBEEF;
        if (n == 20) b_bus = 32'h0;
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL b2b_first_done got %0d dones want 1", dones);
    end
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d want 34", n);
    end
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL b2b_first_result got %h want %h", result, 32'd14);
    end
    start = 1'b1; funct3 = 3'b100; a_bus = 32'hFFFFFFF9; b_bus = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_bus = $urandom; b_bus = $urandom;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    n = 1; dones = 0;
    while (n <= 60 && dones == 0) begin
      if (done === 1'b1) dones++;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (n !== 34 || dones !== 1) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d (dones %0d) want 34 (1)", n, dones);
    end
    checks++;
    if (result !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL b2b_second_result got %h want %h", result, 32'hFFFFFFFD);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int dones;
    run_op(3'b000, 32'd3, 32'd5, "pre_reset_mul");
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a_bus = 32'h1234; b_bus = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || result !== 32'd15) begin
      errors++;
      $display("FAIL mid_op_state got busy=%b result=%h want busy=1 result=%h", busy, result, 32'd15);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result} !== 34'h0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset got %0d active cycles want 0", dones);
    end
    run_op(3'b000, 32'h1234, 32'h5678, "post_reset_mul");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
